// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: NUM_CH packed producer channels in, one tagged beat stream out.
// Handshake: a beat moves on a channel exactly in the cycle where valid and ready are both high;
// valid never waits on ready, and once offered a beat stays put until it is taken.
interface rr_stream_mux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_last;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel registered stream mux with round-robin arbitration and a source-channel tag.
// Define RR_STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_stream_mux #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  rr_stream_mux_if.slave  bus,
  output logic [CH_W-1:0] dbg_ptr
);

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   next_ptr;
  logic [NUM_CH-1:0] grant;
  logic              found;
  logic              load_en;
  logic              take;
  int                idx;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic              lock_active;
  logic [CH_W-1:0]   lock_ch;
`endif

  // The output register can take a beat when it is empty or its beat leaves this cycle.
  assign load_en = !bus.out_valid | bus.out_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    if (lock_active) begin
      // Mid-packet: only the locked channel may move, even while it idles.
      grant_idx       = lock_ch;
      grant[lock_ch]  = bus.in_valid[lock_ch];
    end else
`endif
    begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && bus.in_valid[idx]) begin
          found     = 1'b1;
          grant[idx] = 1'b1;
          grant_idx = CH_W'(idx);
        end
      end
    end
  end

  assign take         = load_en & (|grant);
  assign bus.in_ready = grant & {NUM_CH{load_en & reset_n}};
  assign next_ptr     = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
  assign dbg_ptr      = rr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_last  <= 1'b0;
      rr_ptr        <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_active   <= 1'b0;
      lock_ch       <= '0;
`endif
    end else if (load_en) begin
      bus.out_valid <= take;
      if (take) begin
        bus.out_data <= bus.in_data[grant_idx*WIDTH +: WIDTH];
        bus.out_ch   <= grant_idx;
        bus.out_last <= bus.in_last[grant_idx];
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        lock_active  <= !bus.in_last[grant_idx];
        lock_ch      <= grant_idx;
        if (bus.in_last[grant_idx]) rr_ptr <= next_ptr;
`else
        rr_ptr       <= next_ptr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux (WIDTH=8, NUM_CH=4) with hand-computed expectations.
module tb_rr_stream_mux;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic            clk;
  logic            reset_n;
  logic [CH_W-1:0] dbg_ptr;
  int              vec_cnt;
  int              err_cnt;

  rr_stream_mux_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  rr_stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .dbg_ptr (dbg_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ch(input int i, input logic [WIDTH-1:0] d, input logic last);
    bus.in_data[i*WIDTH +: WIDTH] = d;
    bus.in_last[i]                = last;
  endtask

  task automatic test_reset();
    reset_n       = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 4'hF;
    bus.in_last   = '0;
    bus.out_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    vec_cnt++; if (bus.out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    vec_cnt++; if (bus.out_ch !== 2'd0) begin err_cnt++; $display("FAIL reset_out_ch: got %0d want 0", bus.out_ch); end
    vec_cnt++; if (bus.out_last !== 1'b0) begin err_cnt++; $display("FAIL reset_out_last: got %0b want 0", bus.out_last); end
    vec_cnt++; if (bus.in_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
    vec_cnt++; if (dbg_ptr !== 2'd0) begin err_cnt++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n      = 1'b1;
    bus.in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_out_valid: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 8'h10 + 8'(i), 1'b0);
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    vec_cnt++; if (bus.in_ready !== 4'b0001) begin err_cnt++; $display("FAIL rr_first_ready: got %b want 0001", bus.in_ready); end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      exp_d = 8'h10 + 8'(c % 4);
      vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL rr_valid[%0d]: got %0b want 1", c, bus.out_valid); end
      vec_cnt++; if (bus.out_ch !== 2'(c % 4)) begin err_cnt++; $display("FAIL rr_ch[%0d]: got %0d want %0d", c, bus.out_ch, c % 4); end
      vec_cnt++; if (bus.out_data !== exp_d) begin err_cnt++; $display("FAIL rr_data[%0d]: got %h want %h", c, bus.out_data, exp_d); end
    end
    @(negedge clk);
    bus.in_valid = '0;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_drain_valid: got %0b want 0", bus.out_valid); end
    vec_cnt++; if (dbg_ptr !== 2'd0) begin err_cnt++; $display("FAIL rr_ptr: got %0d want 0", dbg_ptr); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_ch(2, 8'hA5, 1'b1);
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    vec_cnt++; if (bus.in_ready !== 4'b0100) begin err_cnt++; $display("FAIL single_ready: got %b want 0100", bus.in_ready); end
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_data !== 8'hA5) begin err_cnt++; $display("FAIL single_data: got %h want a5", bus.out_data); end
    vec_cnt++; if (bus.out_ch !== 2'd2) begin err_cnt++; $display("FAIL single_ch: got %0d want 2", bus.out_ch); end
    vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid: got %0b want 1", bus.out_valid); end
    vec_cnt++; if (bus.out_last !== 1'b1) begin err_cnt++; $display("FAIL single_last: got %0b want 1", bus.out_last); end
    vec_cnt++; if (dbg_ptr !== 2'd3) begin err_cnt++; $display("FAIL single_ptr: got %0d want 3", dbg_ptr); end
    @(negedge clk);
    bus.in_valid = '0;
    bus.in_last  = '0;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_drain: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap_skip();
    // ptr=3: ch3 beat first, then ch1 alone (ptr 0 -> ch1 -> ptr 2), then ch0 alone (wraps -> ptr 1).
    @(negedge clk);
    set_ch(3, 8'h3C, 1'b0);
    bus.in_valid = 4'b1000;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_ch !== 2'd3) begin err_cnt++; $display("FAIL wrap_ch3: got %0d want 3", bus.out_ch); end
    @(negedge clk);
    set_ch(1, 8'h1C, 1'b0);
    bus.in_valid = 4'b0010;
    #1;
    vec_cnt++; if (bus.in_ready !== 4'b0010) begin err_cnt++; $display("FAIL skip_ready: got %b want 0010", bus.in_ready); end
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_ch !== 2'd1) begin err_cnt++; $display("FAIL skip_ch: got %0d want 1", bus.out_ch); end
    vec_cnt++; if (bus.out_data !== 8'h1C) begin err_cnt++; $display("FAIL skip_data: got %h want 1c", bus.out_data); end
    vec_cnt++; if (dbg_ptr !== 2'd2) begin err_cnt++; $display("FAIL skip_ptr: got %0d want 2", dbg_ptr); end
    @(negedge clk);
    set_ch(0, 8'h0C, 1'b0);
    bus.in_valid = 4'b0001;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_ch !== 2'd0) begin err_cnt++; $display("FAIL wrap_ch0: got %0d want 0", bus.out_ch); end
    vec_cnt++; if (dbg_ptr !== 2'd1) begin err_cnt++; $display("FAIL wrap_ptr: got %0d want 1", dbg_ptr); end
    @(negedge clk);
    bus.in_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_ch(1, 8'h33, 1'b0);
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_data !== 8'h33) begin err_cnt++; $display("FAIL bp_load: got %h want 33", bus.out_data); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_ch(2, 8'h44, 1'b0);
    bus.in_valid  = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec_cnt++; if (bus.in_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, bus.in_ready); end
      @(posedge clk); #1;
      vec_cnt++; if (bus.out_data !== 8'h33 || bus.out_ch !== 2'd1 || bus.out_valid !== 1'b1)
        begin err_cnt++; $display("FAIL bp_hold[%0d]: got %h/%0d/%0b want 33/1/1", c, bus.out_data, bus.out_ch, bus.out_valid); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    vec_cnt++; if (bus.in_ready !== 4'b0100) begin err_cnt++; $display("FAIL bp_release_ready: got %b want 0100", bus.in_ready); end
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_data !== 8'h44 || bus.out_ch !== 2'd2) begin err_cnt++; $display("FAIL bp_next: got %h/%0d want 44/2", bus.out_data, bus.out_ch); end
    @(negedge clk);
    bus.in_valid = '0;
    @(posedge clk); #1;
    vec_cnt++; if (dbg_ptr !== 2'd3) begin err_cnt++; $display("FAIL bp_ptr: got %0d want 3", dbg_ptr); end
  endtask

  task automatic test_packet();
    // ch0 offers a 3-beat packet, ch1 offers single-beat packets every cycle; ptr starts at 3.
    logic [1:0] exp_ch [6];
    logic [7:0] exp_dt [6];
    int         b;
    logic       took0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    exp_ch = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    exp_dt = '{8'hC0, 8'hC1, 8'hC2, 8'h51, 8'h51, 8'h51};
`else
    exp_ch = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    exp_dt = '{8'hC0, 8'h51, 8'hC1, 8'h51, 8'hC2, 8'h51};
`endif
    b = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      set_ch(0, 8'hC0 + 8'(b), (b == 2));
      set_ch(1, 8'h51, 1'b1);
      bus.in_valid = {2'b00, 1'b1, (b < 3)};
      #1;
      took0 = bus.in_ready[0];
      @(posedge clk); #1;
      vec_cnt++; if (bus.out_ch !== exp_ch[c] || bus.out_data !== exp_dt[c] || bus.out_valid !== 1'b1)
        begin err_cnt++; $display("FAIL pkt_beat[%0d]: got ch%0d/%h/%0b want ch%0d/%h/1", c, bus.out_ch, bus.out_data, bus.out_valid, exp_ch[c], exp_dt[c]); end
      if (took0) b++;
    end
    @(negedge clk);
    bus.in_valid = '0;
    bus.in_last  = '0;
    @(posedge clk); #1;
    vec_cnt++; if (dbg_ptr !== 2'd2) begin err_cnt++; $display("FAIL pkt_ptr: got %0d want 2", dbg_ptr); end
  endtask

  task automatic test_reset_mid();
    // ptr=2, only ch0 valid -> ch0 granted, ptr 1, beat held by out_ready=0; reset discards it.
    @(negedge clk);
    set_ch(0, 8'h77, 1'b1);
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_data !== 8'h77 || dbg_ptr !== 2'd1) begin err_cnt++; $display("FAIL mid_load: got %h/ptr%0d want 77/ptr1", bus.out_data, dbg_ptr); end
    #1 reset_n = 1'b0;
    #1;
    vec_cnt++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0)
      begin err_cnt++; $display("FAIL mid_reset_out: got %0b/%h/%0b want 0/00/0", bus.out_valid, bus.out_data, bus.out_last); end
    vec_cnt++; if (dbg_ptr !== 2'd0) begin err_cnt++; $display("FAIL mid_reset_ptr: got %0d want 0", dbg_ptr); end
    vec_cnt++; if (bus.in_ready !== 4'b0000) begin err_cnt++; $display("FAIL mid_reset_ready: got %b want 0000", bus.in_ready); end
    @(negedge clk);
    reset_n      = 1'b1;
    bus.in_valid = '0;
    @(posedge clk); #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_after_valid: got %0b want 0", bus.out_valid); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap_skip();
    test_backpressure();
    test_packet();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
